// File: rtl/serializador_tx_if.sv
// Serializer bus: parallel word and load handshake going in, framed serial
// line and frame status coming out. The master side supplies words and the
// slave side is the serializer itself.
interface serializador_tx_if #(
    parameter int DATA_W = 5
);
    logic [DATA_W-1:0] data;
    logic              load;
    logic              ready;
    logic              x;
    logic              busy;
    logic              done;

    modport master (
        output data,
        output load,
        input  ready,
        input  x,
        input  busy,
        input  done
    );

    modport slave (
        input  data,
        input  load,
        output ready,
        output x,
        output busy,
        output done
    );
endinterface

// File: rtl/serializador_tx.sv
// Framed parallel-in / serial-out transmitter.
// Frame: START bit (1), DATA_W payload bits LSB first, optional even-parity
// bit, STOP bit (0). The line idles at 0.
// The idle level and the start level are the reverse of the usual UART
// convention: x=0 when idle and x=1 for the start bit.
// A word is accepted when load=1 while ready=1. ready is high in IDLE and in
// STOP, so frames can be chained with no idle gap.
// Build option: define SERIALIZADOR_TX_PARITY_EN to insert the PAR state,
// which sends the XOR of the captured word between the last data bit and STOP.
// Reset is asynchronous and active-low. It aborts any frame in progress.
module serializador_tx #(
    parameter int DATA_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    serializador_tx_if.slave   bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
`ifdef SERIALIZADOR_TX_PARITY_EN
        , PAR = 3'd4
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              x_q, x_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
`ifdef SERIALIZADOR_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    logic accept;

    assign accept = bus.load && ready_q;

    // Next state, datapath and next output values.
    // Every output is computed from the state being entered, so the flops
    // show each state's value during that state's own cycle.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        x_d     = 1'b0;
`ifdef SERIALIZADOR_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE, STOP: begin
                if (accept) begin
                    state_d = START;
                    shift_d = bus.data;
                    x_d     = 1'b1;
`ifdef SERIALIZADOR_TX_PARITY_EN
                    par_d   = ^bus.data;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = DATA;
                x_d     = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == LAST_BIT) begin
`ifdef SERIALIZADOR_TX_PARITY_EN
                    state_d = PAR;
                    x_d     = par_q;
`else
                    state_d = STOP;
                    x_d     = 1'b0;
`endif
                end else begin
                    x_d     = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`ifdef SERIALIZADOR_TX_PARITY_EN
            PAR: begin
                state_d = STOP;
                x_d     = 1'b0;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE) || (state_d == STOP);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == STOP);
    end

    // State, datapath and registered outputs.
    // Reset drops the frame in progress and returns to an idle line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef SERIALIZADOR_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifdef SERIALIZADOR_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.x     = x_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_serializador_tx.sv
// Testbench for serializador_tx.
// A scoreboard queue holds one expected {x,busy,done,ready} entry per cycle.
// Entries are pushed when the bench sees a load accepted at a clock edge.
// They are popped and compared at the following falling edge.
// An empty queue means the block is expected to be idle.
module tb_serializador_tx;

    localparam int DATA_W = 5;
`ifdef SERIALIZADOR_TX_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 3;
`else
    localparam int FRAME_LEN = DATA_W + 2;
`endif

    typedef struct packed {
        logic x;
        logic busy;
        logic done;
        logic ready;
    } obs_t;

    localparam obs_t IDLE_OBS = 4'b0001;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    obs_t exp_q[$];
    logic exp_ready = 1'b1;
    int   n_checks  = 0;
    int   n_errors  = 0;

    serializador_tx_if #(.DATA_W(DATA_W)) bus ();

    serializador_tx #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Queue the expected cycles of one whole frame for word w.
    task automatic push_frame(input logic [DATA_W-1:0] w);
        exp_q.push_back(obs_t'(4'b1100));
        for (int i = 0; i < DATA_W; i++) begin
            exp_q.push_back(obs_t'({w[i], 1'b1, 1'b0, 1'b0}));
        end
`ifdef SERIALIZADOR_TX_PARITY_EN
        exp_q.push_back(obs_t'({^w, 1'b1, 1'b0, 1'b0}));
`endif
        exp_q.push_back(obs_t'(4'b0111));
    endtask

    // Advance one clock cycle.
    // At the rising edge, record an acceptance in the scoreboard.
    // At the falling edge, return the observed outputs and the expected entry.
    task automatic step(output obs_t obs, output obs_t expv, output logic acc);
        @(posedge clk);
        acc = reset && bus.load && exp_ready;
        if (acc) push_frame(bus.data);
        @(negedge clk);
        if (exp_q.size() != 0) expv = exp_q.pop_front();
        else                   expv = IDLE_OBS;
        obs = obs_t'({bus.x, bus.busy, bus.done, bus.ready});
        exp_ready = expv.ready;
    endtask

    task automatic test_reset();
        obs_t obs, expv;
        logic acc;
        bus.load = 1'b0;
        bus.data = '0;
        #2 reset = 1'b0;
        #1;
        obs = obs_t'({bus.x, bus.busy, bus.done, bus.ready});
        n_checks++;
        if (obs !== IDLE_OBS) begin
            n_errors++;
            $display("[TB] FAIL reset_async x/busy/done/ready got %b required %b", obs, IDLE_OBS);
        end
        for (int i = 0; i < 2; i++) begin
            step(obs, expv, acc);
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("[TB] FAIL reset_hold[%0d] got %b required %b", i, obs, expv);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(obs, expv, acc);
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("[TB] FAIL reset_idle[%0d] got %b required %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_single_frame(input logic [DATA_W-1:0] word);
        obs_t obs, expv;
        logic acc;
        int   done_cnt = 0;
        int   busy_cnt = 0;
        bus.data = word;
        bus.load = 1'b1;
        for (int i = 0; i < FRAME_LEN + 4; i++) begin
            step(obs, expv, acc);
            bus.load = 1'b0;
            bus.data = ~word;
            if (obs.done) done_cnt++;
            if (obs.busy) busy_cnt++;
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("[TB] FAIL frame_%b[%0d] got %b required %b", word, i, obs, expv);
            end
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_errors++;
            $display("[TB] FAIL frame_%b_done_pulses got %0d required 1", word, done_cnt);
        end
        n_checks++;
        if (busy_cnt !== FRAME_LEN) begin
            n_errors++;
            $display("[TB] FAIL frame_%b_length got %0d required %0d", word, busy_cnt, FRAME_LEN);
        end
    endtask

    task automatic test_back_to_back();
        obs_t obs, expv;
        logic acc;
        int   n_acc      = 0;
        int   first_done = -1;
        int   second_acc = -1;
        bus.data = 5'b00001;
        bus.load = 1'b1;
        for (int i = 0; i < 2 * FRAME_LEN + 4; i++) begin
            step(obs, expv, acc);
            if (acc) begin
                n_acc++;
                if (n_acc == 2) second_acc = i;
            end
            if (n_acc == 1) bus.data = 5'b11111;
            if (n_acc >= 2) bus.load = 1'b0;
            if (obs.done && first_done < 0) first_done = i;
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("[TB] FAIL b2b[%0d] got %b required %b", i, obs, expv);
            end
        end
        bus.load = 1'b0;
        n_checks++;
        if (second_acc !== first_done + 1) begin
            n_errors++;
            $display("[TB] FAIL b2b_gap second start at %0d required %0d", second_acc, first_done + 1);
        end
    endtask

    task automatic test_ignored_load();
        obs_t obs, expv;
        logic acc;
        int   busy_cnt = 0;
        bus.data = 5'b01010;
        bus.load = 1'b1;
        for (int i = 0; i < FRAME_LEN + 4; i++) begin
            step(obs, expv, acc);
            bus.load = (i == 2);
            bus.data = (i == 2) ? 5'b11111 : 5'b01010;
            if (obs.busy) busy_cnt++;
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("[TB] FAIL ignored_load[%0d] got %b required %b", i, obs, expv);
            end
        end
        n_checks++;
        if (busy_cnt !== FRAME_LEN) begin
            n_errors++;
            $display("[TB] FAIL ignored_load_busy_cycles got %0d required %0d", busy_cnt, FRAME_LEN);
        end
    endtask

    task automatic test_abort();
        obs_t obs, expv;
        logic acc;
        int   done_cnt = 0;
        bus.data = 5'b10110;
        bus.load = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(obs, expv, acc);
            bus.load = 1'b0;
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("[TB] FAIL abort_pre[%0d] got %b required %b", i, obs, expv);
            end
        end
        #2 reset = 1'b0;
        #1;
        obs = obs_t'({bus.x, bus.busy, bus.done, bus.ready});
        exp_q.delete();
        exp_ready = 1'b1;
        n_checks++;
        if (obs !== IDLE_OBS) begin
            n_errors++;
            $display("[TB] FAIL abort_immediate got %b required %b", obs, IDLE_OBS);
        end
        for (int i = 0; i < 2; i++) begin
            step(obs, expv, acc);
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("[TB] FAIL abort_hold[%0d] got %b required %b", i, obs, expv);
            end
        end
        reset = 1'b1;
        bus.data = 5'b01101;
        bus.load = 1'b1;
        for (int i = 0; i < FRAME_LEN + 3; i++) begin
            step(obs, expv, acc);
            bus.load = 1'b0;
            if (obs.done) done_cnt++;
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("[TB] FAIL abort_after[%0d] got %b required %b", i, obs, expv);
            end
        end
        n_checks++;
        if (done_cnt !== 1) begin
            n_errors++;
            $display("[TB] FAIL abort_after_done_pulses got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_random_words();
        obs_t obs, expv;
        logic acc;
        int   waited;
        for (int k = 0; k < 6; k++) begin
            bus.data = DATA_W'($urandom);
            bus.load = 1'b1;
            acc = 1'b0;
            waited = 0;
            while (!acc && waited < 3 * FRAME_LEN) begin
                step(obs, expv, acc);
                waited++;
                n_checks++;
                if (obs !== expv) begin
                    n_errors++;
                    $display("[TB] FAIL random[%0d] got %b required %b", k, obs, expv);
                end
            end
            bus.load = 1'b0;
            if (!acc) begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL random_accept_timeout word %0d waited %0d cycles", k, waited);
            end
            for (int g = 0; g < int'($urandom_range(FRAME_LEN + 2, FRAME_LEN - 1)); g++) begin
                step(obs, expv, acc);
                n_checks++;
                if (obs !== expv) begin
                    n_errors++;
                    $display("[TB] FAIL random_gap[%0d] got %b required %b", k, obs, expv);
                end
            end
        end
        for (int i = 0; i < FRAME_LEN + 2; i++) begin
            step(obs, expv, acc);
            n_checks++;
            if (obs !== expv) begin
                n_errors++;
                $display("[TB] FAIL random_drain[%0d] got %b required %b", i, obs, expv);
            end
        end
    endtask

    // Run the scenarios in order and print the summary.
    initial begin
        bus.data = '0;
        bus.load = 1'b0;
        test_reset();
        test_single_frame(5'b10110);
        test_single_frame(5'b00111);
        test_back_to_back();
        test_ignored_load();
        test_abort();
        test_random_words();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serializador_tx.md
SERIALIZADOR_TX -- requirements
Module: serializador_tx

Interface
REQ-001 Parameter DATA_W, default 5: number of payload bits per frame, >= 2.
REQ-002 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port data, input, DATA_W: parallel word to transmit; sampled only on an accepted load.
REQ-005 Port load, input, 1: request to transmit data; accepted when load=1 and ready=1 at a rising clk edge.
REQ-006 Port ready, output, 1: block can accept a word this cycle.
REQ-007 Port x, output, 1: registered serial line; this line is the serial input of the team's shift-register receiver.
REQ-008 Port busy, output, 1: a frame is in progress, from the start bit through the stop bit.
REQ-009 Port done, output, 1: one-cycle pulse during the stop-bit cycle.

Function
REQ-010 The block SHALL be a parallel-in, serial-out framed transmitter with states IDLE, START, DATA, PAR and STOP.
REQ-011 IDLE SHALL drive x=0, ready=1 and busy=0.
REQ-012 An accepted load at edge E SHALL capture data into an internal shift register and enter START.
  - START drives x=1 for exactly one cycle: E to E+1.
REQ-013 DATA SHALL drive data bit 0 first and bit DATA_W-1 last, one bit per cycle, on cycles E+1 to E+DATA_W.
  - Purpose: the word lands in receiver positions s[DATA_W-1:0] unreversed.
REQ-014 DATA SHALL be counted by a bit counter of ceil(log2(DATA_W)) bits.
  - The counter clears on entry to DATA.
  - The last bit is sent when counter = DATA_W-1, with no wrap beyond DATA_W-1.
REQ-015 After DATA the block SHALL enter PAR if the parity feature is compiled in, otherwise STOP.
REQ-016 STOP SHALL drive x=0, busy=1, done=1 and ready=1 for exactly one cycle.
REQ-017 A load accepted during STOP SHALL start the next frame with a START bit in the very next cycle.
  - No idle gap is inserted between back-to-back frames.
REQ-018 A STOP cycle without load SHALL go to IDLE.
REQ-019 Frame length SHALL be DATA_W+2 cycles, or DATA_W+3 with parity.
REQ-020 Outside IDLE and STOP, ready SHALL be 0, and load and data SHALL be ignored.
  - An in-flight frame is never corrupted or truncated by input changes.
REQ-021 load=1 held continuously SHALL transmit the word present at each acceptance edge, back-to-back.
REQ-022 x, busy, ready and done SHALL be registered outputs with no combinational path from load or data.

Reset
REQ-023 reset=0 SHALL immediately force IDLE, x=0, busy=0, done=0, ready=1, and clear the shift register and bit counter to 0.
REQ-024 reset asserted mid-frame SHALL abort the frame with no stop bit and no done pulse; the captured word is discarded.
REQ-025 The first load accepted after reset deassertion SHALL be handled exactly as in REQ-012.

Configuration
REQ-026 Macro SERIALIZADOR_TX_PARITY_EN SHALL compile the PAR state in or out.
REQ-027 With SERIALIZADOR_TX_PARITY_EN defined, PAR SHALL drive x = XOR of all DATA_W captured bits (even parity) for one cycle between DATA and STOP.
REQ-028 Without SERIALIZADOR_TX_PARITY_EN, no PAR state or parity logic SHALL exist, and DATA is followed directly by STOP.

Verification
REQ-029 Reset and idle: reset=0 for 2 cycles, then reset=1, load=0 for 5 cycles -> x=0, ready=1, busy=0, done=0 throughout.
REQ-030 Single frame, DATA_W=5, no parity: data=5'b10110 accepted at edge E -> x sequence 1,0,1,1,0,1,0 on cycles E..E+6.
  - done=1 only on cycle E+6; ready=0 on cycles E..E+5.
REQ-031 Parity enabled: data=5'b00111 -> x sequence 1,1,1,1,0,0,1,0.
  - The parity bit is 1 (three ones in the word); the frame is 8 cycles.
REQ-032 Back-to-back: load held at 1 with data=5'b00001 then 5'b11111 -> second START immediately follows first STOP.
  - Full sequence: 1,1,0,0,0,0,0,1,1,1,1,1,1,0, with no extra idle cycle.
REQ-033 Mid-frame abort: reset=0 during the third data bit -> x=0 and ready=1 immediately, with no done pulse.
  - A new load after reset=1 sends a complete, correct frame.
REQ-034 Ignored load: pulse load with data=5'b11111 while busy and ready=0 -> the in-flight frame is unchanged and no second frame follows.
